// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: widths, opcodes, flag bit
// positions and the sequencer state encoding.
package alu_sequencer_pkg;

    localparam int OPERAND_WIDTH = 8;
    localparam int SEL_WIDTH     = 5;
    localparam int MUL_STEPS     = 8;
    localparam int MUL_COUNT_W   = 3;

    localparam logic [SEL_WIDTH-1:0] OP_ADD  = 5'd0;
    localparam logic [SEL_WIDTH-1:0] OP_SUB  = 5'd1;
    localparam logic [SEL_WIDTH-1:0] OP_AND  = 5'd2;
    localparam logic [SEL_WIDTH-1:0] OP_OR   = 5'd3;
    localparam logic [SEL_WIDTH-1:0] OP_XOR  = 5'd4;
    localparam logic [SEL_WIDTH-1:0] OP_SLT  = 5'd5;
    localparam logic [SEL_WIDTH-1:0] OP_DIV  = 5'd6;
    localparam logic [SEL_WIDTH-1:0] OP_MULT = 5'd7;
    localparam logic [SEL_WIDTH-1:0] OP_MFHI = 5'd8;
    localparam logic [SEL_WIDTH-1:0] OP_MFLO = 5'd9;

    localparam int FLG_ERROR = 3;
    localparam int FLG_OVF   = 2;
    localparam int FLG_CARRY = 1;
    localparam int FLG_ZERO  = 0;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_EXEC,
        SEQ_MUL,
        SEQ_RESP
    } seq_state_t;

    function automatic logic [3:0] pack_flags(input logic error, input logic ovf,
                                              input logic carry, input logic zero);
        logic [3:0] f;
        f            = '0;
        f[FLG_ERROR] = error;
        f[FLG_OVF]   = ovf;
        f[FLG_CARRY] = carry;
        f[FLG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, response and ALU-drive bundle between control logic, the
// sequencer (slave) and the combinational ALU.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [SEL_WIDTH-1:0]     cmd_op;
    logic [OPERAND_WIDTH-1:0] cmd_a;
    logic [OPERAND_WIDTH-1:0] cmd_b;

    logic [OPERAND_WIDTH-1:0] alu_a;
    logic [OPERAND_WIDTH-1:0] alu_b;
    logic [SEL_WIDTH-1:0]     alu_sel;
    logic [OPERAND_WIDTH-1:0] alu_out;
    logic                     alu_error;
    logic                     alu_zero;
    logic                     alu_carry;
    logic                     alu_overflow;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [OPERAND_WIDTH-1:0] rsp_data;
    logic [3:0]               rsp_flags;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_error, alu_zero, alu_carry, alu_overflow,
        output rsp_valid, rsp_data, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_error, alu_zero, alu_carry, alu_overflow,
        input  rsp_valid, rsp_data, rsp_flags,
        output rsp_ready
    );

endinterface

// File: rtl/alu_sequencer_mul_step_ctrl.sv
// HI/LO/multiplicand/step-count state for the shift-add multiply that runs
// through the ALU's ADD path, one step per cycle.
module mul_step_ctrl
    import alu_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    input  logic [OPERAND_WIDTH-1:0] start_a,
    input  logic [OPERAND_WIDTH-1:0] start_b,
    input  logic [OPERAND_WIDTH-1:0] sum,
    input  logic                     sum_carry,
    output logic [OPERAND_WIDTH-1:0] hi,
    output logic [OPERAND_WIDTH-1:0] lo,
    output logic [OPERAND_WIDTH-1:0] addend,
    output logic [OPERAND_WIDTH-1:0] hi_next,
    output logic [OPERAND_WIDTH-1:0] lo_next,
    output logic                     last_step
);

    logic [OPERAND_WIDTH-1:0] mcand;
    logic [MUL_COUNT_W-1:0]   count;

    // The ALU addend depends only on the registered LO[0], keeping the step path short.
    assign addend    = lo[0] ? mcand : '0;
    assign hi_next   = {sum_carry, sum[OPERAND_WIDTH-1:1]};
    assign lo_next   = {sum[0], lo[OPERAND_WIDTH-1:1]};
    assign last_step = (count == MUL_COUNT_W'(MUL_STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            count <= '0;
        end else if (start) begin
            hi    <= '0;
            lo    <= start_b;
            mcand <= start_a;
            count <= '0;
        end else if (step) begin
            hi    <= hi_next;
            lo    <= lo_next;
            count <= count + MUL_COUNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready command front-end for the combinational ALU: one operation in
// flight, registered response, HI/LO-backed multiply and move-from ops.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    alu_sequencer_if.slave       bus,
    output logic                 busy
);

    seq_state_t state, state_next;

    logic [SEL_WIDTH-1:0]     op;
    logic [OPERAND_WIDTH-1:0] a;
    logic [OPERAND_WIDTH-1:0] b;
    logic [OPERAND_WIDTH-1:0] rsp_data;
    logic [3:0]               rsp_flags;

    logic                     accept;
    logic                     mul_start;
    logic                     mul_step;
    logic                     mul_last;
    logic [OPERAND_WIDTH-1:0] hi, lo, addend, hi_next, lo_next;

    mul_step_ctrl u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .step      (mul_step),
        .start_a   (bus.cmd_a),
        .start_b   (bus.cmd_b),
        .sum       (bus.alu_out),
        .sum_carry (bus.alu_carry),
        .hi        (hi),
        .lo        (lo),
        .addend    (addend),
        .hi_next   (hi_next),
        .lo_next   (lo_next),
        .last_step (mul_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEQ_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_sel   = '0;
        accept        = 1'b0;
        mul_start     = 1'b0;
        mul_step      = 1'b0;
        case (state)
            SEQ_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (bus.cmd_op == OP_MFHI || bus.cmd_op == OP_MFLO) begin
                        state_next = SEQ_RESP;
                    end else if (bus.cmd_op == OP_MULT) begin
                        mul_start  = 1'b1;
                        state_next = SEQ_MUL;
                    end else begin
                        state_next = SEQ_EXEC;
                    end
                end
            end
            SEQ_EXEC: begin
                bus.alu_sel = op;
                bus.alu_a   = a;
                bus.alu_b   = b;
                state_next  = SEQ_RESP;
            end
            SEQ_MUL: begin
                bus.alu_sel = OP_ADD;
                bus.alu_a   = hi;
                bus.alu_b   = addend;
                mul_step    = 1'b1;
                if (mul_last) state_next = SEQ_RESP;
            end
            SEQ_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    // Response registers only change on accept, EXEC capture or the last multiply step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op        <= '0;
            a         <= '0;
            b         <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept) begin
                op <= bus.cmd_op;
                a  <= bus.cmd_a;
                b  <= bus.cmd_b;
                if (bus.cmd_op == OP_MFHI) begin
                    rsp_data  <= hi;
                    rsp_flags <= pack_flags(1'b0, 1'b0, 1'b0, hi == '0);
                end else if (bus.cmd_op == OP_MFLO) begin
                    rsp_data  <= lo;
                    rsp_flags <= pack_flags(1'b0, 1'b0, 1'b0, lo == '0);
                end
            end
            if (state == SEQ_EXEC) begin
                rsp_data  <= bus.alu_out;
                rsp_flags <= pack_flags(bus.alu_error, bus.alu_overflow,
                                        bus.alu_carry, bus.alu_zero);
            end
            if (mul_step && mul_last) begin
                rsp_data  <= lo_next;
                rsp_flags <= pack_flags(1'b0, 1'b0, hi_next != '0,
                                        {hi_next, lo_next} == '0);
            end
        end
    end

    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_flags = rsp_flags;
    assign busy          = (state != SEQ_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, directed scenarios and random
// commands checked against a product/HI/LO reference model.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] hi_m, lo_m;

    // Returns {error, overflow, carry, zero, result[7:0]}.
    function automatic logic [11:0] alu_fn(input logic [4:0] sel, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] s;
        logic [7:0] r;
        logic e, o, c;
        e = 1'b0; o = 1'b0; c = 1'b0; r = '0; s = '0;
        case (sel)
            OP_ADD: begin s = {1'b0, x} + {1'b0, y}; r = s[7:0]; c = s[8]; o = (x[7] == y[7]) && (r[7] != x[7]); end
            OP_SUB: begin s = {1'b0, x} - {1'b0, y}; r = s[7:0]; c = s[8]; o = (x[7] != y[7]) && (r[7] != x[7]); end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_SLT: r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
            OP_DIV: if (y == 8'd0) e = 1'b1; else r = x / y;
            default: e = 1'b1;
        endcase
        return {e, o, c, (r == 8'd0), r};
    endfunction

    assign {bus.alu_error, bus.alu_overflow, bus.alu_carry, bus.alu_zero, bus.alu_out} =
        alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

    // Reference: multiply is a plain 16-bit product split into HI/LO.
    task automatic model_cmd(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                             output int lat, output logic [7:0] data, output logic [3:0] flags);
        logic [15:0] p;
        logic [11:0] r;
        if (op == OP_MFHI) begin
            lat = 1; data = hi_m; flags = {3'b000, hi_m == 8'd0};
        end else if (op == OP_MFLO) begin
            lat = 1; data = lo_m; flags = {3'b000, lo_m == 8'd0};
        end else if (op == OP_MULT) begin
            p = 16'(a) * 16'(b);
            hi_m = p[15:8]; lo_m = p[7:0];
            lat = 9; data = p[7:0]; flags = {2'b00, p[15:8] != 8'd0, p == 16'd0};
        end else begin
            r = alu_fn(op, a, b);
            lat = 2; data = r[7:0]; flags = r[11:8];
        end
    endtask

    task automatic send_cmd(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input int stall,
                            output int lat, output logic [7:0] data, output logic [3:0] flags);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        bus.rsp_ready = (stall == 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) lat = -1;
        data = bus.rsp_data; flags = bus.rsp_flags;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.rsp_ready = 1'b1;
        hi_m = '0; lo_m = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_flags} !== {1'b0, 1'b1, 1'b0, 8'h00, 4'h0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b ready=%b valid=%b data=%h flags=%b, expected 0 1 0 00 0000",
                     busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_flags);
        end
        checks++;
        if ({bus.alu_sel, bus.alu_a, bus.alu_b} !== 21'd0) begin
            errors++;
            $display("[TB] FAIL reset_alu_drive: got sel=%h a=%h b=%h, expected all 0", bus.alu_sel, bus.alu_a, bus.alu_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int lat, elat; logic [7:0] d, ed; logic [3:0] f, ef;
        model_cmd(OP_ADD, 8'd200, 8'd100, elat, ed, ef);
        send_cmd(OP_ADD, 8'd200, 8'd100, 0, lat, d, f);
        checks++;
        if (lat != 2 || d !== 8'd44 || f !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL add_200_100: got lat=%0d data=%0d flags=%b, expected lat=2 data=44 flags=0010", lat, d, f);
        end
    endtask

    task automatic test_mult_moves;
        int lat, elat; logic [7:0] d, ed; logic [3:0] f, ef;
        model_cmd(OP_MULT, 8'hFF, 8'hFF, elat, ed, ef);
        send_cmd(OP_MULT, 8'hFF, 8'hFF, 0, lat, d, f);
        checks++;
        if (lat != 9 || d !== 8'h01 || f !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL mult_ff_ff: got lat=%0d data=%h flags=%b, expected lat=9 data=01 flags=0010", lat, d, f);
        end
        model_cmd(OP_MFHI, 8'h00, 8'h00, elat, ed, ef);
        send_cmd(OP_MFHI, 8'h00, 8'h00, 0, lat, d, f);
        checks++;
        if (lat != 1 || d !== 8'hFE || f !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mfhi_after_mult: got lat=%0d data=%h flags=%b, expected lat=1 data=fe flags=0000", lat, d, f);
        end
        model_cmd(OP_MFLO, 8'h00, 8'h00, elat, ed, ef);
        send_cmd(OP_MFLO, 8'h00, 8'h00, 0, lat, d, f);
        checks++;
        if (lat != 1 || d !== 8'h01 || f !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mflo_after_mult: got lat=%0d data=%h flags=%b, expected lat=1 data=01 flags=0000", lat, d, f);
        end
    endtask

    task automatic test_div_zero;
        int lat, elat; logic [7:0] d, ed; logic [3:0] f, ef;
        model_cmd(OP_DIV, 8'd10, 8'd0, elat, ed, ef);
        send_cmd(OP_DIV, 8'd10, 8'd0, 0, lat, d, f);
        checks++;
        if (lat != 2 || d !== 8'h00 || f !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL div_by_zero: got lat=%0d data=%h flags=%b, expected lat=2 data=00 flags=1001", lat, d, f);
        end
        model_cmd(OP_MFHI, 8'h00, 8'h00, elat, ed, ef);
        send_cmd(OP_MFHI, 8'h00, 8'h00, 0, lat, d, f);
        checks++;
        if (lat != 1 || d !== 8'hFE) begin
            errors++;
            $display("[TB] FAIL hi_kept_after_div: got lat=%0d data=%h, expected lat=1 data=fe", lat, d);
        end
    endtask

    task automatic test_mult_zero;
        int lat, elat; logic [7:0] d, ed; logic [3:0] f, ef;
        model_cmd(OP_MULT, 8'h00, 8'h37, elat, ed, ef);
        send_cmd(OP_MULT, 8'h00, 8'h37, 0, lat, d, f);
        checks++;
        if (lat != 9 || d !== 8'h00 || f !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mult_zero: got lat=%0d data=%h flags=%b, expected lat=9 data=00 flags=0001", lat, d, f);
        end
        model_cmd(OP_MFHI, 8'h00, 8'h00, elat, ed, ef);
        send_cmd(OP_MFHI, 8'h00, 8'h00, 0, lat, d, f);
        checks++;
        if (lat != 1 || d !== 8'h00 || f !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mfhi_zero: got lat=%0d data=%h flags=%b, expected lat=1 data=00 flags=0001", lat, d, f);
        end
    endtask

    task automatic test_backpressure;
        logic seen;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_SUB; bus.cmd_a = 8'd5; bus.cmd_b = 8'd9;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = (i == 2);
            bus.cmd_op = OP_ADD; bus.cmd_a = 8'd1; bus.cmd_b = 8'd1;
            checks++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_flags} !== {1'b1, 1'b0, 8'hFC, 4'b0010}) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: got valid=%b ready=%b data=%h flags=%b, expected 1 0 fc 0010",
                         i, bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_flags);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL backpressure_release: got busy=%b ready=%b, expected busy=0 ready=1", busy, bus.cmd_ready);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stalled_cmd_dropped: got activity=%b, expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_mul;
        int lat; logic [7:0] d; logic [3:0] f; logic seen;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_MULT; bus.cmd_a = 8'h12; bus.cmd_b = 8'h34;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, bus.alu_sel} !== {1'b1, OP_ADD}) begin
            errors++;
            $display("[TB] FAIL mul_in_progress: got busy=%b sel=%h, expected busy=1 sel=%h", busy, bus.alu_sel, OP_ADD);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, bus.rsp_valid, bus.cmd_ready, bus.alu_sel, bus.alu_a, bus.alu_b} !== {1'b0, 1'b0, 1'b1, 21'd0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_mul: got busy=%b valid=%b ready=%b sel=%h a=%h b=%h, expected 0 1 ready, drives 0",
                     busy, bus.rsp_valid, bus.cmd_ready, bus.alu_sel, bus.alu_a, bus.alu_b);
        end
        @(negedge clk);
        rst = 1'b0;
        hi_m = '0; lo_m = '0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_rsp_after_reset: got rsp_valid seen=%b, expected 0", seen);
        end
        send_cmd(OP_MFLO, 8'h00, 8'h00, 0, lat, d, f);
        checks++;
        if (lat != 1 || d !== 8'h00 || f !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mflo_after_reset: got lat=%0d data=%h flags=%b, expected lat=1 data=00 flags=0001", lat, d, f);
        end
    endtask

    task automatic test_random;
        int lat, elat, stall; logic [7:0] d, ed, a, b; logic [3:0] f, ef; logic [4:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 12));
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            stall = $urandom_range(0, 2);
            model_cmd(op, a, b, elat, ed, ef);
            send_cmd(op, a, b, stall, lat, d, f);
            checks++;
            if (lat != elat || d !== ed || f !== ef) begin
                errors++;
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d data=%h flags=%b, expected lat=%0d data=%h flags=%b",
                         i, op, a, b, lat, d, f, elat, ed, ef);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_mult_moves();
        test_div_zero();
        test_mult_zero();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential command front-end for the 8-bit combinational ALU. Accepts one operation at a time over a valid/ready command port and drives the ALU's `a`/`b`/`sel` inputs. Captures the result and flags into a registered response. Multiplication runs as an 8-step shift-add through the ALU's ADD path into architectural HI/LO registers, which makes `OP_MULT`, `OP_MFHI` and `OP_MFLO` fully functional. The block sits between the instruction/control logic and the ALU.

## Interface
- `OPERAND_WIDTH`, default 8: operand/result width. Only 8 is supported.
- `SEL_WIDTH`, default 5: opcode width. Must equal the ALU selector width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in SEL_WIDTH: opcode (`OP_*`).
- `cmd_a`, `cmd_b` in OPERAND_WIDTH: operands.
- `alu_a`, `alu_b` out OPERAND_WIDTH: ALU operand drive.
- `alu_sel` out SEL_WIDTH: ALU opcode drive.
- `alu_out` in OPERAND_WIDTH: ALU result.
- `alu_error`, `alu_zero`, `alu_carry`, `alu_overflow` in 1 each: ALU flags.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out OPERAND_WIDTH: result.
- `rsp_flags` out 4: {error, overflow, carry, zero}.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - `cmd_ready`=1.
  - A command is accepted when `cmd_valid`=1. On accept, latch op, a and b.
  - `OP_MFLO`/`OP_MFHI` go to RESP with data=LO/HI. Flags are zero=(data==0); all others are 0. The ALU is not used.
  - `OP_MULT` goes to MUL with HI=0, LO=b, mcand=a, count=0.
  - All other opcodes, including undefined ones, go to EXEC.
- EXEC:
  - Drive `alu_sel`=op, `alu_a`=a, `alu_b`=b.
  - Register `alu_out` and the four flags.
  - Go to RESP.
  - An undefined opcode or DIV by 0 returns the ALU's error=1 unmodified.
  - HI/LO are untouched by every op except MULT.
- MUL, one step per cycle, 8 steps:
  - Drive `alu_sel`=`OP_ADD`, `alu_a`=HI, `alu_b`= LO[0] ? mcand : 0.
  - Update: HI <= {alu_carry, alu_out[7:1]}; LO <= {alu_out[0], LO[7:1]}; count++.
  - After step 8, go to RESP with data=LO.
  - Flags: zero=({HI,LO}==0), carry=(HI!=0), error=0, overflow=0.
- RESP:
  - `rsp_valid`=1; data and flags are held stable.
  - When `rsp_ready`=1, go to IDLE.
  - `cmd_ready`=0 in every state except IDLE, so there is no accept/response overlap.
- ALU drive in IDLE/RESP: `alu_a`=`alu_b`=0, `alu_sel`=0.
- Reset at any time, including mid-MUL:
  - State=IDLE; HI=LO=0; `rsp_valid`=0; `rsp_data`=0; `rsp_flags`=0; ALU drives 0.
  - `cmd_ready`=1, `busy`=0.
  - The in-flight command is discarded and no response is produced.

## Timing
- Accept edge = cycle 0.
- Latency to `rsp_valid`=1:
  - EXEC ops: cycle 2.
  - MFLO/MFHI: cycle 1.
  - MULT: cycle 9, i.e. 8 MUL cycles plus RESP.
- Minimum throughput with `rsp_ready` held high: one EXEC op per 3 cycles, one MFHI/MFLO per 2 cycles, one MULT per 10 cycles.
- The EXEC capture path is combinational: ALU inputs come from registers and the ALU result is registered in the same cycle, so it must close in one clock.
- The MUL ALU drive depends on the current LO[0] only, which is a register bit.
- Backpressure: while `rsp_ready`=0, `rsp_*` stay constant and further commands stall.

## Structure
- Opcode constants (`OP_*`), `OPERAND_WIDTH` and `SEL_WIDTH` come from `ALU_constants.vh`.
- Add to `ALU_constants.vh`:
  - state encodings `SEQ_IDLE`/`SEQ_EXEC`/`SEQ_MUL`/`SEQ_RESP`;
  - flag bit indices `FLG_ERROR`=3, `FLG_OVF`=2, `FLG_CARRY`=1, `FLG_ZERO`=0.
- The ALU is instantiated outside this block, at system level and in the bench.
- One natural sub-module: `mul_step_ctrl`, which holds HI/LO/mcand/count and the shift update. The FSM stays in `alu_sequencer`.

## Test plan
- ADD a=200 b=100, `rsp_ready`=1 -> `rsp_valid` at cycle 2, data=44, flags carry=1, zero=0, error=0.
- MULT a=0xFF b=0xFF -> `rsp_valid` at cycle 9, data=0x01, carry=1. Then MFHI -> 0xFE and MFLO -> 0x01, each valid at cycle 1.
- DIV a=10 b=0 after a prior MULT -> data=0, error=1. A following MFHI still returns the prior HI.
- MULT a=0x00 b=0x37 -> data=0x00, zero=1, carry=0. Then MFHI -> 0x00, zero=1.
- SUB a=5 b=9 with `rsp_ready`=0 for 5 cycles -> data=0xFC held constant, `cmd_ready`=0, a `cmd_valid` pulse in that window is not accepted, IDLE after the ready handshake.
- Assert `rst` during MUL step 4 of MULT a=0x12 b=0x34 -> `rsp_valid` never rises, `busy`=0 immediately, a subsequent MFLO returns 0x00.
